// File: rtl/mult_seq_param.sv
// Sequential shift-add multiplier: one partial product per clock, WIDTH-bit
// operands, 2*WIDTH-bit product, optional two's-complement mode.
module mult_seq_param #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned SIGNED_EN = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [WIDTH-1:0]   a_bi,
  input  logic [WIDTH-1:0]   b_bi,
  input  logic               signed_i,
  input  logic               start_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] y_bo
);

  localparam int unsigned PW  = 2 * WIDTH;
  localparam int unsigned CW  = $clog2(WIDTH) + 1;
  localparam bit          SEN = (SIGNED_EN != 0);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WORK = 1'b1
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   ctr_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic            sgn_q;
  logic [PW-1:0]   acc_q;
  logic [PW-1:0]   y_q;
  logic            busy_q;
  logic            done_q;

  logic [PW-1:0]    a_ext;
  logic [WIDTH-1:0] b_sh;
  logic             b_bit;
  logic             last;
  logic [PW-1:0]    pp;
  logic [PW-1:0]    acc_d;

  // Partial product for bit b[ctr]; the MSB term is subtracted in signed mode
  always_comb begin
    a_ext = {{WIDTH{a_q[WIDTH-1] & sgn_q}}, a_q};
    b_sh  = b_q >> ctr_q;
    b_bit = b_sh[0];
    last  = (ctr_q == CW'(WIDTH - 1));
    pp    = b_bit ? (a_ext << ctr_q) : '0;
    acc_d = (sgn_q && last) ? (acc_q - pp) : (acc_q + pp);
  end

  // Control FSM, operand capture, accumulation and result/strobe registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ctr_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      acc_q   <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            a_q     <= a_bi;
            b_q     <= b_bi;
            sgn_q   <= signed_i & SEN;
            ctr_q   <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_WORK;
          end
        end
        S_WORK: begin
          acc_q <= acc_d;
          ctr_q <= ctr_q + CW'(1);
          if (last) begin
            y_q     <= acc_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign y_bo   = y_q;

endmodule

// File: tb/tb_mult_seq_param.sv
// Scoreboard bench for mult_seq_param: an 8-bit signed-capable instance and a
// 16-bit unsigned-only instance share one clock.
module tb_mult_seq_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 8-bit instance
  logic [7:0]  a8 = '0, b8 = '0;
  logic        s8 = 1'b0, st8 = 1'b0;
  logic        busy8, done8;
  logic [15:0] y8;

  // 16-bit instance, signed mode disabled
  logic [15:0] a16 = '0, b16 = '0;
  logic        s16 = 1'b0, st16 = 1'b0;
  logic        busy16, done16;
  logic [31:0] y16;

  mult_seq_param #(.WIDTH(8), .SIGNED_EN(1)) dut8 (
    .clk_i(clk), .rst_i(rst), .a_bi(a8), .b_bi(b8), .signed_i(s8),
    .start_i(st8), .busy_o(busy8), .done_o(done8), .y_bo(y8)
  );

  mult_seq_param #(.WIDTH(16), .SIGNED_EN(0)) dut16 (
    .clk_i(clk), .rst_i(rst), .a_bi(a16), .b_bi(b16), .signed_i(s16),
    .start_i(st16), .busy_o(busy16), .done_o(done16), .y_bo(y16)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic [15:0] q8[$];
  logic [31:0] q16[$];
  int bc8 = 0, bc16 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor for the 8-bit instance: result on done, and busy length before it
  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) begin
        check("unexpected_done8", 32'(done8), 32'd0);
      end else begin
        check("y8", 32'(y8), 32'(q8.pop_front()));
        check("busy8_len", 32'(bc8), 32'd8);
      end
      bc8 = 0;
    end else if (busy8) begin
      bc8++;
    end else begin
      bc8 = 0;
    end
  end

  // Monitor for the 16-bit instance
  always @(negedge clk) begin
    if (done16) begin
      if (q16.size() == 0) begin
        check("unexpected_done16", 32'(done16), 32'd0);
      end else begin
        check("y16", y16, q16.pop_front());
        check("busy16_len", 32'(bc16), 32'd16);
      end
      bc16 = 0;
    end else if (busy16) begin
      bc16++;
    end else begin
      bc16 = 0;
    end
  end

  // Wait (bounded) until all issued 8-bit ops have been checked
  task automatic drain8();
    int n = 0;
    while (q8.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (q8.size() != 0) begin
      check("timeout8", 32'(q8.size()), 32'd0);
      q8.delete();
    end
    @(negedge clk);
  endtask

  task automatic drain16();
    int n = 0;
    while (q16.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (q16.size() != 0) begin
      check("timeout16", 32'(q16.size()), 32'd0);
      q16.delete();
    end
    @(negedge clk);
  endtask

  // Issue one 8-bit op at a negedge; accepted at the next rising edge
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                     input logic [15:0] exp);
    a8 = a; b8 = b; s8 = s; st8 = 1'b1;
    q8.push_back(exp);
    @(negedge clk);
    st8 = 1'b0;
    drain8();
  endtask

  initial begin
    int t0;
    int t1;
    int n;

    repeat (2) @(negedge clk);
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_done8", 32'(done8), 32'd0);
    check("rst_y8", 32'(y8), 32'd0);
    check("rst_y16", y16, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Unsigned and signed directed products
    op8(8'hFF, 8'hFF, 1'b0, 16'hFE01);
    op8(8'hFF, 8'hFF, 1'b1, 16'h0001);
    op8(8'h80, 8'h7F, 1'b1, 16'hC080);
    op8(8'h80, 8'h80, 1'b1, 16'h4000);
    op8(8'h05, 8'hFD, 1'b1, 16'hFFF1);
    op8(8'h7F, 8'h02, 1'b1, 16'h00FE);
    op8(8'h00, 8'hAB, 1'b0, 16'h0000);
    op8(8'h80, 8'h80, 1'b0, 16'h4000);
    op8(8'hFF, 8'h80, 1'b0, 16'h7F80);

    // Start held high: back-to-back ops with period WIDTH+1
    a8 = 8'd3; b8 = 8'd5; s8 = 1'b0; st8 = 1'b1;
    q8.push_back(16'h000F);
    n = 0;
    do begin @(negedge clk); n++; end while (!done8 && n < 30);
    t0 = cyc;
    a8 = 8'd7; b8 = 8'd9;
    q8.push_back(16'h003F);
    @(negedge clk);
    st8 = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!done8 && n < 30);
    t1 = cyc;
    check("b2b_period", 32'(t1 - t0), 32'd9);
    drain8();

    // Start pulse and operand change during WORK are ignored
    a8 = 8'h12; b8 = 8'h34; s8 = 1'b0; st8 = 1'b1;
    q8.push_back(16'h03A8);
    @(negedge clk);
    st8 = 1'b0;
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; s8 = 1'b1; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    drain8();

    // Asynchronous reset mid-WORK
    a8 = 8'hAB; b8 = 8'hCD; s8 = 1'b0; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_y8", 32'(y8 != 16'h0), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy8", 32'(busy8), 32'd0);
    check("midrst_y8", 32'(y8), 32'd0);
    check("midrst_done8", 32'(done8), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("post_rst_nodone", 32'(q8.size()), 32'd0);
    op8(8'h0A, 8'h0B, 1'b0, 16'h006E);

    // 16-bit unsigned-only instance ignores signed_i
    a16 = 16'hFFFF; b16 = 16'hFFFF; s16 = 1'b1; st16 = 1'b1;
    q16.push_back(32'hFFFE0001);
    @(negedge clk);
    st16 = 1'b0;
    drain16();
    a16 = 16'h8000; b16 = 16'h0003; s16 = 1'b1; st16 = 1'b1;
    q16.push_back(32'h00018000);
    @(negedge clk);
    st16 = 1'b0;
    drain16();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
